// File: rtl/led_fb_update_ctrl.sv
// Double-buffered frame store for the 16x16, 4-level LED matrix.
// The scanner reads the front bank; two writers share the back bank under
// round-robin arbitration. Bulk clears and frame-synchronous swaps are sequenced
// so the scanner never displays a half-updated frame.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   p0_*/p1_*                  writer ports: valid/row/col/level in, ready out (combinational)
//   clear_req, swap_req        one-cycle request pulses (sticky until serviced)
//   frame_end                  scanner end-of-frame pulse
//   rd_row, rd_col, rd_level   front-bank read, 1-cycle latency
//   front_bank                 bank currently displayed
//   clear_busy                 init or clear sweep in progress
//   swap_pending, swap_done    swap status
module led_fb_update_ctrl #(
    parameter int unsigned N_CELLS  = 256,
    parameter int unsigned CLR_LAST = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p0_valid,
    input  logic [3:0] p0_row,
    input  logic [3:0] p0_col,
    input  logic [1:0] p0_level,
    output logic       p0_ready,
    input  logic       p1_valid,
    input  logic [3:0] p1_row,
    input  logic [3:0] p1_col,
    input  logic [1:0] p1_level,
    output logic       p1_ready,
    input  logic       clear_req,
    input  logic       swap_req,
    input  logic       frame_end,
    input  logic [3:0] rd_row,
    input  logic [3:0] rd_col,
    output logic [1:0] rd_level,
    output logic       front_bank,
    output logic       clear_busy,
    output logic       swap_pending,
    output logic       swap_done
);

    localparam int unsigned ADDR_W = 8;
    localparam logic [ADDR_W-1:0] INIT_END = ADDR_W'(N_CELLS - 1);
    localparam logic [ADDR_W-1:0] CLR_END  = ADDR_W'(CLR_LAST);

    localparam logic [1:0] S_INIT      = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_CLEAR     = 2'd2;
    localparam logic [1:0] S_WAIT_SWAP = 2'd3;

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              clr_pend, swap_pend;
    logic              last;
    logic              clr_done_c, swap_exec_c, grant_ok_c;
    logic              wr_both_c, wr_back_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [1:0]        wr_data_c;

    logic [1:0] mem0 [N_CELLS];
    logic [1:0] mem1 [N_CELLS];

    assign swap_pending = swap_pend;

    // Next-state, arbitration and write-port selection.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        clr_done_c  = 1'b0;
        swap_exec_c = 1'b0;
        wr_both_c   = 1'b0;
        wr_back_c   = 1'b0;
        wr_addr_c   = addr;
        wr_data_c   = 2'd0;

        // Writers are served only while nothing is pending, so a clear or swap
        // request freezes the back bank from the cycle after it is seen.
        grant_ok_c = (state == S_IDLE) && !clr_pend && !swap_pend;
        // last = 1 means port 1 won most recently, so port 0 wins a tie.
        p0_ready   = grant_ok_c && p0_valid && (!p1_valid || last);
        p1_ready   = grant_ok_c && p1_valid && (!p0_valid || !last);

        case (state)
            S_INIT: begin
                wr_both_c = 1'b1;
                addr_n    = addr + ADDR_W'(1);
                if (addr == INIT_END) begin
                    addr_n  = '0;
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr_pend) begin
                    state_n = S_CLEAR;
                    addr_n  = '0;
                end else if (swap_pend) begin
                    state_n = S_WAIT_SWAP;
                end
                if (p0_ready) begin
                    wr_back_c = 1'b1;
                    wr_addr_c = {p0_row, p0_col};
                    wr_data_c = p0_level;
                end else if (p1_ready) begin
                    wr_back_c = 1'b1;
                    wr_addr_c = {p1_row, p1_col};
                    wr_data_c = p1_level;
                end
            end
            S_CLEAR: begin
                wr_back_c = 1'b1;
                addr_n    = addr + ADDR_W'(1);
                if (addr == CLR_END) begin
                    clr_done_c = 1'b1;
                    addr_n     = '0;
                    state_n    = S_IDLE;
                end
            end
            S_WAIT_SWAP: begin
                if (frame_end) begin
                    swap_exec_c = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_INIT;
        endcase
    end

    // Control state, sticky request flags and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            addr       <= '0;
            clr_pend   <= 1'b0;
            swap_pend  <= 1'b0;
            last       <= 1'b1;
            front_bank <= 1'b0;
            swap_done  <= 1'b0;
            clear_busy <= 1'b1;
            rd_level   <= 2'd0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            // A new request in the servicing cycle re-arms the flag.
            clr_pend   <= clear_req || (clr_pend && !clr_done_c);
            swap_pend  <= swap_req || (swap_pend && !swap_exec_c);
            if (p0_ready) begin
                last <= 1'b0;
            end else if (p1_ready) begin
                last <= 1'b1;
            end
            if (swap_exec_c) begin
                front_bank <= !front_bank;
            end
            swap_done  <= swap_exec_c;
            clear_busy <= (state_n == S_INIT) || (state_n == S_CLEAR);
            rd_level   <= front_bank ? mem1[{rd_row, rd_col}] : mem0[{rd_row, rd_col}];
        end
    end

    // Bank storage; the back bank is always the one not displayed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_both_c || (wr_back_c && front_bank)) begin
                mem0[wr_addr_c] <= wr_data_c;
            end
            if (wr_both_c || (wr_back_c && !front_bank)) begin
                mem1[wr_addr_c] <= wr_data_c;
            end
        end
    end

endmodule

// File: tb/tb_led_fb_update_ctrl.sv
// Scoreboard bench for led_fb_update_ctrl: stimulus pushes expected grants,
// swap completions and read data; a negedge monitor pops and compares.
module tb_led_fb_update_ctrl;

    logic       clk;
    logic       rst;
    logic       p0_valid, p1_valid;
    logic [3:0] p0_row, p0_col, p1_row, p1_col;
    logic [1:0] p0_level, p1_level;
    logic       p0_ready, p1_ready;
    logic       clear_req, swap_req, frame_end;
    logic [3:0] rd_row, rd_col;
    logic [1:0] rd_level;
    logic       front_bank, clear_busy, swap_pending, swap_done;

    int checks = 0;
    int errors = 0;

    int exp_grant[$];
    int exp_done[$];
    int exp_rd[$];

    logic [1:0] mdl [2][256];
    logic       mdl_front;
    logic       rd_chk, rd_pipe;

    localparam int SWP = 0;
    localparam int CLR = 1;
    localparam int FE  = 2;

    led_fb_update_ctrl dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_row(p0_row), .p0_col(p0_col), .p0_level(p0_level), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_row(p1_row), .p1_col(p1_col), .p1_level(p1_level), .p1_ready(p1_ready),
        .clear_req(clear_req), .swap_req(swap_req), .frame_end(frame_end),
        .rd_row(rd_row), .rd_col(rd_col), .rd_level(rd_level),
        .front_bank(front_bank), .clear_busy(clear_busy),
        .swap_pending(swap_pending), .swap_done(swap_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rd_pipe <= rd_chk;

    // Monitor: pops expectations whenever the DUT presents a grant, swap or read.
    always @(negedge clk) begin : mon
        int g;
        g = -1;
        if (p0_valid && p0_ready) g = 0;
        if (p1_valid && p1_ready) g = 1;
        if (g >= 0) begin
            chk("single_grant", int'(p0_ready && p1_ready), 0);
            if (exp_grant.size() == 0) chk("grant_unexpected", g, -1);
            else chk("grant_port", g, exp_grant.pop_front());
        end
        if (swap_done) begin
            if (exp_done.size() == 0) chk("swap_done_unexpected", int'(swap_done), 0);
            else chk("swap_front_bank", int'(front_bank), exp_done.pop_front());
        end
        if (rd_pipe && exp_rd.size() > 0) chk("rd_level", int'(rd_level), exp_rd.pop_front());
    end

    task automatic pulse(input int which);
        @(posedge clk); #1;
        case (which)
            SWP:     swap_req  = 1'b1;
            CLR:     clear_req = 1'b1;
            default: frame_end = 1'b1;
        endcase
        @(posedge clk); #1;
        swap_req  = 1'b0;
        clear_req = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic do_swap();
        pulse(SWP);
        @(negedge clk);
        chk("swap_pending_set", int'(swap_pending), 1);
        repeat (2) @(posedge clk);
        exp_done.push_back(int'(!mdl_front));
        mdl_front = !mdl_front;
        pulse(FE);
        repeat (2) @(posedge clk);
        chk("swap_pending_clear", int'(swap_pending), 0);
    endtask

    task automatic read_cell(input int addr);
        logic [7:0] av;
        av = 8'(addr);
        @(posedge clk); #1;
        rd_row = av[7:4];
        rd_col = av[3:0];
        rd_chk = 1'b1;
        exp_rd.push_back(int'(mdl[mdl_front][av]));
        @(posedge clk); #1;
        rd_chk = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic read_all();
        logic [7:0] av;
        for (int a = 0; a < 256; a++) begin
            av = 8'(a);
            @(posedge clk); #1;
            rd_row = av[7:4];
            rd_col = av[3:0];
            rd_chk = 1'b1;
            exp_rd.push_back(int'(mdl[mdl_front][av]));
        end
        @(posedge clk); #1;
        rd_chk = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // One write accepted per cycle from a single port, consecutive addresses.
    task automatic burst(input int port, input int start, input int n, input int lb, input int ls);
        logic [7:0] av;
        logic [1:0] lv;
        for (int i = 0; i < n; i++) begin
            av = 8'(start + i);
            lv = 2'(lb + ls * i);
            @(posedge clk); #1;
            if (port == 0) begin
                p0_valid = 1'b1; p0_row = av[7:4]; p0_col = av[3:0]; p0_level = lv;
            end else begin
                p1_valid = 1'b1; p1_row = av[7:4]; p1_col = av[3:0]; p1_level = lv;
            end
            exp_grant.push_back(port);
            mdl[!mdl_front][av] = lv;
        end
        @(posedge clk); #1;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
    endtask

    task automatic reset_model();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) mdl[b][a] = 2'd0;
        mdl_front = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ok;
        rst = 1'b1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        p0_row = 4'd0; p0_col = 4'd0; p0_level = 2'd0;
        p1_row = 4'd0; p1_col = 4'd0; p1_level = 2'd0;
        clear_req = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
        rd_row = 4'd0; rd_col = 4'd0; rd_chk = 1'b0;
        reset_model();

        // Reset values, then INIT length with p0 held valid.
        p0_valid = 1'b1; p0_row = 4'd3; p0_col = 4'd5; p0_level = 2'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_front_bank", int'(front_bank), 0);
        chk("rst_swap_done", int'(swap_done), 0);
        chk("rst_clear_busy", int'(clear_busy), 1);
        chk("rst_swap_pending", int'(swap_pending), 0);
        chk("rst_p0_ready", int'(p0_ready), 0);
        chk("rst_rd_level", int'(rd_level), 0);
        exp_grant.push_back(0);
        mdl[1][8'h35] = 2'd2;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (p0_ready) break;
            cnt++;
        end
        chk("init_ready_low_cycles", cnt, 256);
        chk("init_clear_busy_done", int'(clear_busy), 0);
        @(posedge clk); #1;
        p0_valid = 1'b0;
        do_swap();
        read_cell(8'h35);

        // p1 alone, then both ports tied: strict alternation starting with p0.
        burst(1, 0, 3, 1, 1);
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_row = 4'd4; p0_col = 4'd4; p0_level = 2'd1;
        p1_valid = 1'b1; p1_row = 4'd4; p1_col = 4'd5; p1_level = 2'd3;
        for (int i = 0; i < 6; i++) exp_grant.push_back(i % 2);
        mdl[!mdl_front][8'h44] = 2'd1;
        mdl[!mdl_front][8'h45] = 2'd3;
        repeat (6) @(posedge clk);
        #1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        do_swap();
        read_cell(8'h01);
        read_cell(8'h44);
        read_cell(8'h45);
        read_cell(8'h35);

        // Write held through WAIT_SWAP lands in the new back bank.
        pulse(SWP);
        p0_valid = 1'b1; p0_row = 4'd7; p0_col = 4'd7; p0_level = 2'd3;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (p0_ready) cnt++;
        end
        chk("wait_swap_ready_low", cnt, 0);
        exp_done.push_back(int'(!mdl_front));
        mdl_front = !mdl_front;
        exp_grant.push_back(0);
        mdl[!mdl_front][8'h77] = 2'd3;
        pulse(FE);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (p0_ready) begin ok = 1; break; end
        end
        chk("wait_swap_accept", ok, 1);
        @(posedge clk); #1;
        p0_valid = 1'b0;
        do_swap();
        read_cell(8'h77);

        // Fill back bank with 3s, clear it, swap requested mid-clear.
        burst(0, 0, 256, 3, 0);
        pulse(CLR);
        for (int a = 0; a < 256; a++) mdl[!mdl_front][a] = 2'd0;
        cnt = 0;
        fork
            begin
                for (int i = 0; i < 700; i++) begin
                    @(negedge clk);
                    if (clear_busy) cnt++;
                    else if (cnt > 0) break;
                end
            end
            begin
                repeat (10) @(posedge clk);
                pulse(SWP);
                repeat (40) @(posedge clk);
                pulse(FE);
            end
        join
        chk("clear_busy_cycles", cnt, 256);
        chk("clear_front_unchanged", int'(front_bank), int'(mdl_front));
        chk("clear_swap_pending", int'(swap_pending), 1);
        repeat (5) @(posedge clk);
        exp_done.push_back(int'(!mdl_front));
        mdl_front = !mdl_front;
        pulse(FE);
        repeat (2) @(posedge clk);
        read_all();

        // Reset in the middle of a clear with a swap pending.
        pulse(CLR);
        repeat (10) @(posedge clk);
        pulse(SWP);
        repeat (88) @(posedge clk);
        @(negedge clk);
        chk("midclr_pending_before", int'(swap_pending), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midclr_swap_pending", int'(swap_pending), 0);
        chk("midclr_front_bank", int'(front_bank), 0);
        chk("midclr_clear_busy", int'(clear_busy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model();
        repeat (260) @(posedge clk);
        @(negedge clk);
        chk("midclr_init_done", int'(clear_busy), 0);
        chk("midclr_pending_after", int'(swap_pending), 0);
        read_all();
        do_swap();
        read_all();

        // Three merged swap requests, one toggle; a later frame_end does nothing.
        pulse(SWP);
        pulse(SWP);
        pulse(SWP);
        repeat (2) @(posedge clk);
        exp_done.push_back(int'(!mdl_front));
        mdl_front = !mdl_front;
        pulse(FE);
        repeat (4) @(posedge clk);
        pulse(FE);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("merged_front_bank", int'(front_bank), int'(mdl_front));
        chk("merged_swap_pending", int'(swap_pending), 0);

        repeat (5) @(posedge clk);
        chk("grant_queue_empty", exp_grant.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
